id_ex_stage: RTL

- ID/EX pipeline register and operand-selection stage for the pipelined MIPS core; sits directly upstream of the ALU.
- Captures decoded operands and controls each cycle, detects load-use hazards and inserts bubbles.
- Applies EX/MEM and MEM/WB forwarding, then drives the ALU operand, operation and branch-mode inputs plus the controls that travel on to MEM.

---
 rtl/id_ex_stage.sv | 133 +++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and EX/MEM, MEM/WB forwarding
module id_ex_stage #(
    parameter int DW   = 32,
    parameter int RW   = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            ex_hold,
    input  logic            id_valid,
    input  logic [RW-1:0]   id_rs,
    input  logic [RW-1:0]   id_rt,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_uses_rs,
    input  logic            id_uses_rt,
    input  logic [DW-1:0]   id_rs_data,
    input  logic [DW-1:0]   id_rt_data,
    input  logic [DW-1:0]   id_imm,
    input  logic            id_alu_src,
    input  logic [3:0]      id_alu_op,
    input  logic [1:0]      id_branch_eq_nq,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            id_mem_to_reg,
    input  logic            exm_reg_write,
    input  logic [RW-1:0]   exm_rd,
    input  logic [DW-1:0]   exm_result,
    input  logic            mwb_reg_write,
    input  logic [RW-1:0]   mwb_rd,
    input  logic [DW-1:0]   mwb_result,
    output logic            id_stall,
    output logic [DW-1:0]   alu_data_a,
    output logic [DW-1:0]   alu_data_b,
    output logic [3:0]      alu_operation,
    output logic [1:0]      alu_branch_eq_nq,
    output logic [DW-1:0]   ex_store_data,
    output logic [RW-1:0]   ex_rd,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_mem_to_reg,
    output logic [CNTW-1:0] bubble_count
);
    logic          hazard;
    logic [RW-1:0] ex_rs;
    logic [RW-1:0] ex_rt;
    logic [DW-1:0] ex_rs_data;
    logic [DW-1:0] ex_rt_data;
    logic [DW-1:0] ex_imm;
    logic          ex_alu_src;
    logic [3:0]    ex_alu_op;
    logic [1:0]    ex_branch;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // A load in EX whose result ID needs cannot be forwarded in time.
    always_comb begin
        hazard = ex_valid & ex_mem_read & (ex_rd != '0) & id_valid &
                 ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
    end

    assign id_stall = hazard | ex_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_rd         <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_imm        <= '0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= 4'b0000;
            ex_branch     <= 2'b00;
            bubble_count  <= '0;
        end else if (flush || (!ex_hold && hazard)) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            // Only load-use bubbles are counted; a flush discards the hazard.
            if (!flush && bubble_count != {CNTW{1'b1}})
                bubble_count <= bubble_count + CNTW'(1);
        end else if (!ex_hold) begin
            ex_valid      <= id_valid;
            ex_reg_write  <= id_valid & id_reg_write;
            ex_mem_read   <= id_valid & id_mem_read;
            ex_mem_write  <= id_valid & id_mem_write;
            ex_mem_to_reg <= id_valid & id_mem_to_reg;
            ex_rd         <= id_rd;
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_rs_data    <= id_rs_data;
            ex_rt_data    <= id_rt_data;
            ex_imm        <= id_imm;
            ex_alu_src    <= id_alu_src;
            ex_alu_op     <= id_alu_op;
            ex_branch     <= id_branch_eq_nq;
        end
    end

    // EX/MEM is the younger producer, so it wins over MEM/WB; $0 is never forwarded.
    always_comb begin
        fwd_rs = ex_rs_data;
        if (exm_reg_write && exm_rd != '0 && exm_rd == ex_rs)
            fwd_rs = exm_result;
        else if (mwb_reg_write && mwb_rd != '0 && mwb_rd == ex_rs)
            fwd_rs = mwb_result;
    end

    always_comb begin
        fwd_rt = ex_rt_data;
        if (exm_reg_write && exm_rd != '0 && exm_rd == ex_rt)
            fwd_rt = exm_result;
        else if (mwb_reg_write && mwb_rd != '0 && mwb_rd == ex_rt)
            fwd_rt = mwb_result;
    end

    assign alu_data_a       = fwd_rs;
    assign alu_data_b       = ex_alu_src ? ex_imm : fwd_rt;
    assign ex_store_data    = fwd_rt;
    assign alu_operation    = ex_valid ? ex_alu_op : 4'b0010;
    assign alu_branch_eq_nq = ex_valid ? ex_branch : 2'b00;
endmodule
